// File: rtl/led_pkg.sv
// led_pkg: shared LED mode encoding for the led_blink_ctrl slice
package led_pkg;
  localparam int LED_MODE_W = 2;
  typedef enum logic [LED_MODE_W-1:0] {LED_OFF, LED_ON, LED_BLINK, LED_BREATHE} led_mode_e;
endpackage

// File: rtl/led_channel.sv
// led_channel: one LED channel with blink phase, PWM compare and registered drive
// LED_BREATHE_EN adds the breathe ramp; without it mode 3 drives the LED off.
module led_channel
  import led_pkg::*;
#(
  parameter int PER_W = 16,
  parameter int PWM_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic             we,
  input  led_mode_e        mode_w,
  input  logic [PER_W-1:0] period_w,
  input  logic [PWM_W-1:0] duty_w,
  output logic             led
);
  led_mode_e        mode;
  logic [PER_W-1:0] period, per_cnt, per_max;
  logic [PWM_W-1:0] duty, lvl;
  logic             phase, pwm_on, led_nxt;
  assign per_max = (period == '0) ? '0 : period - 1'b1;
  assign pwm_on  = (&lvl) | (pwm_cnt < lvl);
`ifdef LED_BREATHE_EN
  logic [PWM_W-1:0] ramp;
  logic             up;
  assign lvl = (mode == LED_BREATHE) ? ramp : duty;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || we) begin
      ramp <= '0;
      up   <= 1'b1;
    end else if (tick && mode == LED_BREATHE) begin
      ramp <= up ? ramp + 1'b1 : ramp - 1'b1;
      if (up ? (ramp + 1'b1 == '1) : (ramp == PWM_W'(1))) up <= ~up;
    end
  end
  always_comb
    led_nxt = (mode == LED_ON)      ? pwm_on :
              (mode == LED_BLINK)   ? phase & pwm_on :
              (mode == LED_BREATHE) ? pwm_on : 1'b0;
`else
  assign lvl = duty;
  always_comb
    led_nxt = (mode == LED_ON)    ? pwm_on :
              (mode == LED_BLINK) ? phase & pwm_on : 1'b0;
`endif
  // a write restarts the blink cycle and swallows a coincident tick
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mode    <= LED_OFF;
      period  <= PER_W'(1);
      duty    <= '1;
      per_cnt <= '0;
      phase   <= 1'b1;
      led     <= 1'b0;
    end else begin
      led <= led_nxt;
      if (we) begin
        mode    <= mode_w;
        period  <= period_w;
        duty    <= duty_w;
        per_cnt <= '0;
        phase   <= 1'b1;
      end else if (tick && mode == LED_BLINK) begin
        per_cnt <= (per_cnt == per_max) ? '0 : per_cnt + 1'b1;
        if (per_cnt == per_max) phase <= ~phase;
      end
    end
  end
endmodule

// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl: multi-channel LED driver with shared tick prescaler and PWM counter
// Define LED_BREATHE_EN to enable the breathe mode in every channel.
module led_blink_ctrl
  import led_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CLK_HZ  = 25_000_000,
  parameter int TICK_HZ = 1000,
  parameter int PER_W   = 16,
  parameter int PWM_W   = 8,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_we_i,
  input  logic [CH_W-1:0]       cfg_ch_i,
  input  logic [LED_MODE_W-1:0] cfg_mode_i,
  input  logic [PER_W-1:0]      cfg_period_i,
  input  logic [PWM_W-1:0]      cfg_duty_i,
  output logic                  tick_o,
  output logic [NCH-1:0]        led_o
);
  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  if (DIV < 2) begin : g_div_chk
    $error("led_blink_ctrl: CLK_HZ/TICK_HZ must be at least 2");
  end
  if (NCH < 1 || NCH > 16) begin : g_nch_chk
    $error("led_blink_ctrl: NCH must be 1..16");
  end
  logic [PRE_W-1:0] pre_cnt;
  logic [PWM_W-1:0] pwm_cnt;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      tick_o  <= 1'b0;
    end else begin
      tick_o  <= pre_cnt == PRE_W'(DIV - 1);
      pre_cnt <= (pre_cnt == PRE_W'(DIV - 1)) ? '0 : pre_cnt + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end
  // channel indices >= NCH match no instance, so such writes fall away
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    led_channel #(.PER_W(PER_W), .PWM_W(PWM_W)) u_ch (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .tick     (tick_o),
      .pwm_cnt  (pwm_cnt),
      .we       (cfg_we_i && cfg_ch_i == CH_W'(c)),
      .mode_w   (led_mode_e'(cfg_mode_i)),
      .period_w (cfg_period_i),
      .duty_w   (cfg_duty_i),
      .led      (led_o[c])
    );
  end
endmodule

// File: tb/tb_led_blink_ctrl.sv
// tb_led_blink_ctrl: directed bench with a cycle-level arithmetic model of led_blink_ctrl
module tb_led_blink_ctrl;
  logic       clk = 1'b0, rst_ni = 1'b0, cfg_we_i = 1'b0;
  logic [1:0] cfg_ch_i = '0, cfg_mode_i = '0;
  logic [7:0] cfg_period_i = '0;
  logic [3:0] cfg_duty_i = '0;
  logic       tick_o, tick3;
  logic [3:0] led_o;
  logic [2:0] led3;
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  led_blink_ctrl #(.NCH(4), .CLK_HZ(100), .TICK_HZ(10), .PER_W(8), .PWM_W(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .cfg_we_i(cfg_we_i), .cfg_ch_i(cfg_ch_i),
    .cfg_mode_i(cfg_mode_i), .cfg_period_i(cfg_period_i), .cfg_duty_i(cfg_duty_i),
    .tick_o(tick_o), .led_o(led_o));

  // three channels: channel index 3 is out of range and must be ignored
  led_blink_ctrl #(.NCH(3), .CLK_HZ(100), .TICK_HZ(10), .PER_W(8), .PWM_W(4)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_ni), .cfg_we_i(cfg_we_i), .cfg_ch_i(cfg_ch_i),
    .cfg_mode_i(cfg_mode_i), .cfg_period_i(cfg_period_i), .cfg_duty_i(cfg_duty_i),
    .tick_o(tick3), .led_o(led3));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: n = edges since reset release; ticks land on edges 11, 21, 31, ...
  int         n = 0;
  int         m_mode[4], m_per[4], m_duty[4], m_w[4];
  logic [3:0] exp_led = '0;
  logic       exp_tick = 1'b0;
  bit         run = 1'b0;

  function automatic int ntick(int m);
    return (m < 1) ? 0 : (m - 1) / 10;
  endfunction

  function automatic logic [3:0] model_led(int s);
    logic [3:0] r = '0;
    for (int c = 0; c < 4; c++) begin
      int k = ntick(s) - ntick(m_w[c]);
      int pm = (m_per[c] == 0) ? 1 : m_per[c];
      int lvl = m_duty[c];
      int rp = k % 30;
      logic on;
      if (m_mode[c] == 3) lvl = (rp <= 15) ? rp : 30 - rp;
      on = (lvl == 15) || ((s % 16) < lvl);
      case (m_mode[c])
        1: r[c] = on;
        2: r[c] = on && ((k / pm) % 2 == 0);
`ifdef LED_BREATHE_EN
        3: r[c] = on;
`endif
        default: r[c] = 1'b0;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_ni) begin
      n = 0;
      for (int c = 0; c < 4; c++) begin
        m_mode[c] = 0; m_per[c] = 1; m_duty[c] = 15; m_w[c] = 0;
      end
      exp_led  = '0;
      exp_tick = 1'b0;
    end else begin
      exp_led  = model_led(n);
      exp_tick = ((n + 1) % 10 == 0);
      n++;
      if (cfg_we_i) begin
        m_mode[cfg_ch_i] = int'(cfg_mode_i);
        m_per[cfg_ch_i]  = int'(cfg_period_i);
        m_duty[cfg_ch_i] = int'(cfg_duty_i);
        m_w[cfg_ch_i]    = n;
      end
    end
    run = 1'b1;
  end

  always @(negedge clk) begin
    if (run) begin
      chk("led_o", 32'(led_o), 32'(exp_led));
      chk("tick_o", 32'(tick_o), 32'(exp_tick));
      chk("led_o_nch3", 32'(led3), 32'(exp_led[2:0]));
      chk("tick_o_nch3", 32'(tick3), 32'(exp_tick));
    end
  end

  task automatic wr(int ch, int mode, int per, int duty);
    cfg_ch_i     = 2'(ch);
    cfg_mode_i   = 2'(mode);
    cfg_period_i = 8'(per);
    cfg_duty_i   = 4'(duty);
    cfg_we_i     = 1'b1;
    @(negedge clk);
    cfg_we_i     = 1'b0;
  endtask

  task automatic until_led(int idx, logic val, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (led_o[idx] !== val && cnt < 200);
  endtask

  initial begin
    int c, hi;
    repeat (3) @(negedge clk);
    chk("reset_led", 32'(led_o), 0);
    chk("reset_tick", 32'(tick_o), 0);
    rst_ni = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!tick_o && c < 50);
    chk("first_tick_delay", c, 10);
    c = 0;
    do begin @(negedge clk); c++; end while (!tick_o && c < 50);
    chk("tick_period", c, 10);
    @(negedge clk);
    chk("tick_width", 32'(tick_o), 0);

    wr(0, 1, 0, 15);
    chk("ch0_write_plus1", 32'(led_o[0]), 0);
    @(negedge clk);
    chk("ch0_write_plus2", 32'(led_o[0]), 1);
    repeat (20) @(negedge clk);
    chk("ch0_steady", 32'(led_o[0]), 1);
    chk("others_off", 32'(led_o[3:1]), 0);

    wr(1, 1, 0, 4);
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      hi = 0;
      repeat (16) begin @(negedge clk); hi += int'(led_o[1]); end
      chk("ch1_pwm_high", hi, 4);
    end

    wr(2, 2, 3, 15);
    until_led(2, 1'b0, c);
    until_led(2, 1'b1, c);
    chk("blink3_low_len", c, 30);
    until_led(2, 1'b0, c);
    chk("blink3_high_len", c, 30);

    wr(2, 2, 0, 15);
    until_led(2, 1'b0, c);
    until_led(2, 1'b1, c);
    chk("blink0_low_len", c, 10);

    c = 0;
    while (!tick_o && c < 50) begin @(negedge clk); c++; end
    wr(2, 2, 3, 15);
    @(negedge clk);
    chk("coinc_phase", 32'(led_o[2]), 1);
    until_led(2, 1'b0, c);
    chk("coinc_tick_lost", c, 30);

    wr(3, 1, 0, 15);
    @(negedge clk);
    chk("ch3_on_nch4", 32'(led_o[3]), 1);
    repeat (15) @(negedge clk);

    rst_ni = 1'b0;
    @(negedge clk);
    chk("midrun_reset_led", 32'(led_o), 0);
    chk("midrun_reset_tick", 32'(tick_o), 0);
    rst_ni = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_reset_off", 32'(led_o), 0);

    wr(3, 3, 0, 9);
    @(negedge clk);
    chk("breathe_start_dark", 32'(led_o[3]), 0);
`ifndef LED_BREATHE_EN
    hi = 0;
    repeat (200) begin @(negedge clk); hi += int'(led_o[3]); end
    chk("breathe_disabled_off", hi, 0);
`endif
    repeat (700) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
